// File: rtl/loop_seq_ctrl_if.sv
// Request/status bundle for loop_seq_ctrl: run launch and operands in,
// sticky result, hit counter and run status out.
interface loop_seq_ctrl_if #(
   parameter int IDX_W = 7,
   parameter int OP_W  = 6
);
   logic                    start;
   logic                    clr;
   logic signed [OP_W-1:0]  operand;
   logic [IDX_W-1:0]        bound;
   logic [1:0]              y;
   logic                    busy;
   logic                    done;
   logic [IDX_W-1:0]        hit_count;

   modport master (
      output start, clr, operand, bound,
      input  y, busy, done, hit_count
   );

   modport slave (
      input  start, clr, operand, bound,
      output y, busy, done, hit_count
   );
endinterface

// File: rtl/loop_seq_ctrl.sv
// Iterates idx = 0..bound-1, one iteration per cycle, and accumulates a
// sticky hit flag plus a saturating hit counter across runs.
module loop_seq_ctrl #(
   parameter int IDX_W = 7,
   parameter int OP_W  = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   loop_seq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [IDX_W-1:0]       bnd_q, bnd_d;
   logic signed [OP_W-1:0] op_q, op_d;
   logic [1:0]             y_q, y_d;
   logic [IDX_W-1:0]       hit_q, hit_d;

   logic [IDX_W-1:0]       op_ext;
   logic [IDX_W-1:0]       sum;
   logic                   parity;
   logic [IDX_W-1:0]       sel;
   logic                   cond;
   logic                   last;

   // Iteration datapath, evaluated against the captured operand only
   assign op_ext = IDX_W'(op_q);
   assign sum    = idx_q + op_ext;
   assign parity = ^sum;
   assign sel    = parity ? idx_q : op_ext;
   assign cond   = (sel != '0);
   // bnd_q is never zero while in RUN, so bnd_q-1 cannot underflow there
   assign last   = (idx_q == (bnd_q - IDX_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         bnd_q   <= '0;
         op_q    <= '0;
         y_q     <= 2'b00;
         hit_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         bnd_q   <= bnd_d;
         op_q    <= op_d;
         y_q     <= y_d;
         hit_q   <= hit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      bnd_d   = bnd_q;
      op_d    = op_q;
      y_d     = y_q;
      hit_d   = hit_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.clr) begin
               y_d   = 2'b00;
               hit_d = '0;
            end
            if (bus.start) begin
               op_d    = bus.operand;
               bnd_d   = bus.bound;
               idx_d   = '0;
               state_d = (bus.bound != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            if (cond) begin
               y_d = 2'b01;
               if (hit_q != '1) hit_d = hit_q + IDX_W'(1);
            end
            idx_d = idx_q + IDX_W'(1);
            if (last) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.y         = y_q;
   assign bus.hit_count = hit_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_loop_seq_ctrl.sv
// Directed bench for loop_seq_ctrl: runs are queued with hand-computed
// results; a negedge monitor checks each done pulse against the queue.
module tb_loop_seq_ctrl;
   localparam int IDX_W = 7;
   localparam int OP_W  = 6;

   typedef struct {
      logic [1:0]       y;
      logic [IDX_W-1:0] hit;
      int               cyc;
      string            nm;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   s_chk = 0, s_pass = 0;
   int   m_chk = 0, m_pass = 0;
   exp_t q[$];

   loop_seq_ctrl_if #(.IDX_W(IDX_W), .OP_W(OP_W)) bus ();

   loop_seq_ctrl #(.IDX_W(IDX_W), .OP_W(OP_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      s_chk++;
      if (act === exp) s_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic mchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      m_chk++;
      if (act === exp) m_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Monitor: every done pulse must match the oldest queued run
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (q.size() == 0) begin
            m_chk++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            mchk({e.nm, "_y"},     32'(bus.y),         32'(e.y));
            mchk({e.nm, "_hit"},   32'(bus.hit_count), 32'(e.hit));
            mchk({e.nm, "_cycle"}, cyc,                e.cyc);
         end
      end
   end

   task automatic run(input string nm, input logic c, input logic [OP_W-1:0] op,
                      input logic [IDX_W-1:0] bnd, input logic [1:0] ey,
                      input logic [IDX_W-1:0] eh, input bit push);
      exp_t e;
      @(negedge clk);
      bus.start   = 1'b1;
      bus.clr     = c;
      bus.operand = op;
      bus.bound   = bnd;
      if (push) begin
         e.y   = ey;
         e.hit = eh;
         e.cyc = cyc + 1 + int'(bnd);
         e.nm  = nm;
         q.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.clr   = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while ((q.size() != 0 || bus.busy === 1'b1) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_drain"}, 32'(q.size()), 32'd0);
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.clr     = 1'b0;
      bus.operand = '0;
      bus.bound   = '0;
      #12;
      chk("rst_y",    32'(bus.y),         32'd0);
      chk("rst_busy", 32'(bus.busy),      32'd0);
      chk("rst_done", 32'(bus.done),      32'd0);
      chk("rst_hit",  32'(bus.hit_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run("b1_op1", 1'b0, 6'd1, 7'd1, 2'b00, 7'd0, 1'b1);
      drain("b1_op1");
      run("b1_op3", 1'b0, 6'd3, 7'd1, 2'b01, 7'd1, 1'b1);
      drain("b1_op3");

      // start and clr during a run must be dropped; operand input changes too
      run("b4_op0", 1'b1, 6'd0, 7'd4, 2'b01, 7'd2, 1'b1);
      chk("b4_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      bus.start = 1'b1; bus.clr = 1'b1; bus.operand = 6'd3; bus.bound = 7'd1;
      @(negedge clk);
      bus.start = 1'b0; bus.clr = 1'b0;
      drain("b4_op0");

      run("b0", 1'b0, 6'd3, 7'd0, 2'b01, 7'd2, 1'b1);
      drain("b0");
      run("clr_b1_op3", 1'b1, 6'd3, 7'd1, 2'b01, 7'd1, 1'b1);
      drain("clr_b1_op3");

      run("b127_op0", 1'b1, 6'd0, 7'd127, 2'b01, 7'd63, 1'b1);
      drain("b127_op0");
      run("b127_sat", 1'b0, 6'h3f, 7'd127, 2'b01, 7'd127, 1'b1);
      drain("b127_sat");
      run("clr_y", 1'b1, 6'd1, 7'd1, 2'b00, 7'd0, 1'b1);
      drain("clr_y");

      // Abort a long run with an asynchronous reset between edges
      run("b100", 1'b0, 6'd5, 7'd100, 2'b00, 7'd0, 1'b0);
      repeat (49) @(negedge clk);
      chk("b100_busy", 32'(bus.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_y",    32'(bus.y),         32'd0);
      chk("abort_busy", 32'(bus.busy),      32'd0);
      chk("abort_done", 32'(bus.done),      32'd0);
      chk("abort_hit",  32'(bus.hit_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (110) @(negedge clk);
      chk("abort_idle", 32'(bus.busy), 32'd0);

      run("post_rst", 1'b0, 6'd3, 7'd1, 2'b01, 7'd1, 1'b1);
      drain("post_rst");
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", s_pass + m_pass, s_chk + m_chk);
      $finish;
   end
endmodule
